parity_frame_accum: RTL and testbench
=====================================

PARITY_FRAME_ACCUM -- requirements
Module: parity_frame_accum

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 4: number of 3-bit groups per frame, legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream group present on in_bits.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts a group this cycle.
REQ-006 The block SHALL have port in_bits, input, 3 bits: one group, {A,B,C}.
REQ-007 The block SHALL have port exp_par, input, 1 bit: expected frame parity, sampled with the last group of a frame.
REQ-008 The block SHALL have port out_valid, output, 1 bit: frame result present.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port out_par, output, 1 bit: 1 when the frame holds an odd number of ones.
REQ-011 The block SHALL have port out_err, output, 1 bit: out_par differs from the captured exp_par.
REQ-012 The block SHALL have port err_count, output, 8 bits: count of errored frames delivered.

Function
REQ-013 An input transfer SHALL occur only in a cycle with in_valid=1 and in_ready=1.
REQ-014 Group parity SHALL be the XOR of in_bits[2], in_bits[1] and in_bits[0].
REQ-015 The running parity SHALL be XORed with the group parity on each input transfer.
REQ-016 The FSM SHALL have exactly three states: IDLE (0 groups taken), ACCUM (1..FRAME_LEN-1 groups taken) and DONE (result held).
REQ-017 The IDLE to ACCUM transition SHALL occur on a transfer when FRAME_LEN>1.
REQ-018 On the FRAME_LEN-th transfer, from ACCUM or from IDLE when FRAME_LEN=1, the FSM SHALL enter DONE.
REQ-019 On that same transfer, out_par SHALL load the final parity and exp_par SHALL be captured.
REQ-020 The DONE to IDLE transition SHALL occur on an output transfer (out_valid=1, out_ready=1), clearing the running parity and group count.
REQ-021 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-022 No new frame SHALL start in the cycle of the output transfer; the first group of the next frame is accepted no earlier than the following cycle.
REQ-023 out_valid SHALL be 1 exactly while in DONE, first asserted in the cycle after the last input transfer (latency 1).
REQ-024 out_par and out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Cycles with in_valid=0 in ACCUM SHALL leave the parity and count unchanged (gaps allowed).
REQ-026 out_ready SHALL be ignored outside DONE.

Reset
REQ-027 When reset=1 at a clock edge, the FSM SHALL enter IDLE, and running parity, group count, out_par, out_err and err_count SHALL be 0.
REQ-028 After reset, out_valid SHALL be 0 and in_ready SHALL be 1 from the next cycle.
REQ-029 Reset asserted mid-frame or in DONE SHALL discard the partial frame or pending result with no output transfer.
REQ-030 Reset SHALL take priority over any simultaneous transfer.

Configuration
REQ-031 With macro PARITY_ERR_COUNT_EN defined, err_count SHALL increment by 1 on each output transfer with out_err=1, saturating at 255.
REQ-032 Without PARITY_ERR_COUNT_EN, err_count SHALL be constant 0 and no counter logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-033 Scenario: FRAME_LEN=4, groups 001,011,111,000 with exp_par=0 and out_ready=1 -> out_valid=1 one cycle after the 4th group, out_par=0, out_err=0.
REQ-034 Scenario: FRAME_LEN=4, groups 001,000,000,000 with exp_par=0 -> out_par=1, out_err=1, err_count=1 with the macro defined and 0 without it.
REQ-035 Scenario: out_ready=0 for 5 cycles in DONE while in_valid=1 -> in_ready=0, out_par and out_err stable, no group consumed; the group is taken the cycle after the handshake.
REQ-036 Scenario: reset=1 after 2 of 4 groups -> IDLE; a new frame of 111,111,111,111 yields out_par=0, unaffected by the discarded groups.
REQ-037 Scenario: FRAME_LEN=1, in_valid=1 continuously, out_ready=1, groups 100,110 -> results 1 then 0, one result every 2 cycles.
REQ-038 Scenario: with the macro defined, 256 consecutive errored frames -> err_count saturates at 255.

Source files
------------

// File: rtl/parity_frame_accum.sv
// ---------------------------------------------------------------------------
// parity_frame_accum
//
// Accumulates the parity of a frame made of FRAME_LEN 3-bit groups. Each
// accepted group contributes the XOR of its three bits to a running parity.
// When the last group of a frame is accepted, the final parity is presented
// on out_par together with out_err, which flags a mismatch against the
// expected parity supplied alongside that last group. The result is held
// until the downstream side accepts it; no input is taken meanwhile.
//
// Parameters
//   FRAME_LEN   groups per frame, 1..255 (default 4)
//
// Ports
//   clk         single clock, rising-edge
//   reset       synchronous, active-high
//   in_valid    upstream group present on in_bits
//   in_ready    block accepts a group this cycle (low while a result waits)
//   in_bits     one group {A,B,C}
//   exp_par     expected frame parity, sampled with the last group
//   out_valid   frame result present
//   out_ready   downstream accepts the result
//   out_par     1 when the frame holds an odd number of ones
//   out_err     out_par differs from the expected parity of that frame
//   err_count   number of errored frames delivered, saturating at 255
//
// Build option
//   PARITY_ERR_COUNT_EN  when defined, err_count counts errored frames on
//                        each output transfer; otherwise it is tied to 0
//                        and no counter hardware exists.
// ---------------------------------------------------------------------------
module parity_frame_accum #(
    parameter int FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_bits,
    input  logic       exp_par,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_par,
    output logic       out_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Count value held in ACCUM just before the final group arrives.
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t     state;
    logic       run_par;
    logic [7:0] grp_cnt;
    logic       grp_par;
    logic       in_xfer;
    logic       out_xfer;
    logic       final_par;

    // Handshake qualifiers and the parity contribution of the current group.
    // final_par is what the frame parity becomes if this group is the last.
    always_comb begin
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        grp_par   = in_bits[2] ^ in_bits[1] ^ in_bits[0];
        final_par = run_par ^ grp_par;
    end

    // Frame FSM. in_ready and out_valid are registered alongside the state so
    // they decode it exactly: in_ready is high in IDLE/ACCUM, out_valid is
    // high only in DONE. Leaving DONE returns to IDLE with in_ready going
    // high for the following cycle, so a new frame can never start in the
    // same cycle as the output transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            run_par   <= 1'b0;
            grp_cnt   <= 8'd0;
            out_par   <= 1'b0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        if (FRAME_LEN == 1) begin
                            state     <= DONE;
                            out_par   <= final_par;
                            out_err   <= final_par ^ exp_par;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state   <= ACCUM;
                            run_par <= final_par;
                            grp_cnt <= 8'd1;
                        end
                    end
                end

                ACCUM: begin
                    if (in_xfer) begin
                        if (grp_cnt == LAST_IDX) begin
                            state     <= DONE;
                            out_par   <= final_par;
                            out_err   <= final_par ^ exp_par;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            run_par <= final_par;
                            grp_cnt <= grp_cnt + 8'd1;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        run_par   <= 1'b0;
                        grp_cnt   <= 8'd0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    run_par   <= 1'b0;
                    grp_cnt   <= 8'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Errored frames are counted when they are actually delivered, so a
    // result discarded by reset never reaches the count. Holds at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 8'd0;
        end else if (out_xfer && out_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_parity_frame_accum.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_accum
//
// Directed bench for parity_frame_accum. One instance uses FRAME_LEN=4 for
// the main frame scenarios; a second uses FRAME_LEN=1 for back-to-back
// single-group frames. Inputs change 1 time unit after a rising edge and
// outputs are examined at that same point, away from the active edge.
// Expected error counts depend on whether PARITY_ERR_COUNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_parity_frame_accum;

`ifdef PARITY_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;

    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_bits;
    logic       exp_par;
    logic       out_valid;
    logic       out_ready;
    logic       out_par;
    logic       out_err;
    logic [7:0] err_count;

    logic       in_valid1;
    logic       in_ready1;
    logic [2:0] in_bits1;
    logic       exp_par1;
    logic       out_valid1;
    logic       out_ready1;
    logic       out_par1;
    logic       out_err1;
    logic [7:0] err_count1;

    int checks;
    int errors;
    int exp_ec;

    parity_frame_accum #(.FRAME_LEN(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .exp_par   (exp_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_par   (out_par),
        .out_err   (out_err),
        .err_count (err_count)
    );

    parity_frame_accum #(.FRAME_LEN(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_bits   (in_bits1),
        .exp_par   (exp_par1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_par   (out_par1),
        .out_err   (out_err1),
        .err_count (err_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the FRAME_LEN=4 instance's inputs.
    task automatic applyStimulus(input logic v, input logic [2:0] bits,
                                 input logic ep, input logic ordy);
        in_valid  = v;
        in_bits   = bits;
        exp_par   = ep;
        out_ready = ordy;
    endtask

    // Single comparison point; counts every check and every failure.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_ec = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
        in_valid1  = 1'b0;
        in_bits1   = 3'b000;
        exp_par1   = 1'b0;
        out_ready1 = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_in_ready", 8'(in_ready), 8'd1);
        checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
        checkOutput("rst_out_par", 8'(out_par), 8'd0);
        checkOutput("rst_out_err", 8'(out_err), 8'd0);
        checkOutput("rst_err_count", err_count, 8'd0);
        checkOutput("rst1_in_ready", 8'(in_ready1), 8'd1);

        // Frame 001,011,111,000 exp 0 -> parity 0, no error, latency 1
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b1); tick();
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b1); tick();
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b1); tick();
        checkOutput("f1_valid_early", 8'(out_valid), 8'd0);
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b1); tick();
        checkOutput("f1_out_valid", 8'(out_valid), 8'd1);
        checkOutput("f1_out_par", 8'(out_par), 8'd0);
        checkOutput("f1_out_err", 8'(out_err), 8'd0);
        checkOutput("f1_in_ready_done", 8'(in_ready), 8'd0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1); tick();
        checkOutput("f1_released", 8'(out_valid), 8'd0);
        checkOutput("f1_in_ready", 8'(in_ready), 8'd1);
        checkOutput("f1_err_count", err_count, 8'd0);

        // Frame 001,000,000,000 exp 0 -> parity 1, error; held with backpressure
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0); tick();
        checkOutput("f2_out_valid", 8'(out_valid), 8'd1);
        checkOutput("f2_out_par", 8'(out_par), 8'd1);
        checkOutput("f2_out_err", 8'(out_err), 8'd1);
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_in_ready", 8'(in_ready), 8'd0);
            checkOutput("hold_out_valid", 8'(out_valid), 8'd1);
            checkOutput("hold_out_par", 8'(out_par), 8'd1);
            checkOutput("hold_out_err", 8'(out_err), 8'd1);
        end
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b1); tick();
        if (CNT_EN) exp_ec = exp_ec + 1;
        checkOutput("f2_handshake_valid", 8'(out_valid), 8'd0);
        checkOutput("f2_handshake_ready", 8'(in_ready), 8'd1);
        checkOutput("f2_err_count", err_count, 8'(exp_ec));

        // Waiting group taken now, then two gap cycles, then three more 111s
        tick();
        checkOutput("f3_first_taken", 8'(out_valid), 8'd0);
        applyStimulus(1'b0, 3'b111, 1'b0, 1'b1); tick(); tick();
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b1); tick(); tick();
        checkOutput("f3_gap_count", 8'(out_valid), 8'd0);
        tick();
        checkOutput("f3_out_valid", 8'(out_valid), 8'd1);
        checkOutput("f3_out_par", 8'(out_par), 8'd0);
        checkOutput("f3_out_err", 8'(out_err), 8'd0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1); tick();
        checkOutput("f3_err_count", err_count, 8'(exp_ec));

        // Reset after two groups (with a transfer pending) discards them
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b1); tick();
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b1); tick();
        reset = 1'b1;
        applyStimulus(1'b1, 3'b111, 1'b0, 1'b1); tick();
        reset = 1'b0;
        exp_ec = 0;
        checkOutput("mid_rst_valid", 8'(out_valid), 8'd0);
        checkOutput("mid_rst_ready", 8'(in_ready), 8'd1);
        checkOutput("mid_rst_err_count", err_count, 8'd0);
        applyStimulus(1'b1, 3'b111, 1'b1, 1'b1); tick(); tick(); tick();
        checkOutput("f4_not_yet", 8'(out_valid), 8'd0);
        tick();
        checkOutput("f4_out_valid", 8'(out_valid), 8'd1);
        checkOutput("f4_out_par", 8'(out_par), 8'd0);
        checkOutput("f4_out_err", 8'(out_err), 8'd1);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1); tick();
        if (CNT_EN) exp_ec = exp_ec + 1;
        checkOutput("f4_err_count", err_count, 8'(exp_ec));

        // Reset while a result is pending drops it without counting
        applyStimulus(1'b1, 3'b001, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 3'b000, 1'b0, 1'b0); tick(); tick(); tick();
        checkOutput("f5_out_valid", 8'(out_valid), 8'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1); tick();
        reset = 1'b0;
        exp_ec = 0;
        checkOutput("done_rst_valid", 8'(out_valid), 8'd0);
        checkOutput("done_rst_err_count", err_count, 8'd0);

        // FRAME_LEN=1: continuous valid, one result every two cycles
        in_valid1  = 1'b1;
        in_bits1   = 3'b100;
        exp_par1   = 1'b0;
        out_ready1 = 1'b1;
        tick();
        checkOutput("fl1_a_valid", 8'(out_valid1), 8'd1);
        checkOutput("fl1_a_par", 8'(out_par1), 8'd1);
        checkOutput("fl1_a_err", 8'(out_err1), 8'd1);
        checkOutput("fl1_a_in_ready", 8'(in_ready1), 8'd0);
        in_bits1 = 3'b110;
        tick();
        checkOutput("fl1_gap_valid", 8'(out_valid1), 8'd0);
        checkOutput("fl1_gap_ready", 8'(in_ready1), 8'd1);
        tick();
        checkOutput("fl1_b_valid", 8'(out_valid1), 8'd1);
        checkOutput("fl1_b_par", 8'(out_par1), 8'd0);
        checkOutput("fl1_b_err", 8'(out_err1), 8'd0);
        in_valid1 = 1'b0;
        tick();
        checkOutput("fl1_err_count", err_count1, CNT_EN ? 8'd1 : 8'd0);

        // 256 consecutive errored frames: count saturates at 255
        for (int f = 1; f <= 256; f++) begin
            applyStimulus(1'b1, 3'b001, 1'b0, 1'b1); tick();
            applyStimulus(1'b1, 3'b000, 1'b0, 1'b1); tick(); tick(); tick();
            applyStimulus(1'b0, 3'b000, 1'b0, 1'b1); tick();
            if (CNT_EN && exp_ec < 255) exp_ec = exp_ec + 1;
            if (f == 1 || f == 255 || f == 256)
                checkOutput("sat_err_count", err_count, 8'(exp_ec));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
